// File: rtl/adder_seq_chain.sv
// rtl/adder_seq_chain.sv - sequential multi-word adder front end with carry chaining
//
// Adds two multi-word operands streamed least-significant word first, one
// word pair per accepted beat, reusing a single BW_DATA-wide adder. The
// carry-out of each word is registered and fed back as the next word's
// carry-in. Results leave through a one-entry valid/ready output register.
//
// Optional feature: define ADDER_SEQ_OVF_EN to build signed-overflow
// detection on o_ovf; otherwise o_ovf is constant 0.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_valid      upstream beat valid
//   o_ready      beat can be accepted this cycle (!o_valid || i_ready)
//   i_first      beat is the first word of an operand pair
//   i_last       beat is the last word of an operand pair
//   i_a, i_b     operand words
//   i_cin        carry-in, used only on a first word
//   o_valid      result word valid
//   i_ready      downstream accepts the result
//   o_sum        result word
//   o_last       result word closes the packet
//   o_cout       final carry-out, only with o_last
//   o_nwords     word count of the completed packet, only with o_last
//   o_frame_err  one-cycle pulse on a protocol error
//   o_ovf        signed overflow of the whole packet sum, only with o_last

module adder_seq_chain #(
  parameter int BW_DATA = 8,
  parameter int BW_CNT  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_first,
  input  logic               i_last,
  input  logic [BW_DATA-1:0] i_a,
  input  logic [BW_DATA-1:0] i_b,
  input  logic               i_cin,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BW_DATA-1:0] o_sum,
  output logic               o_last,
  output logic               o_cout,
  output logic [BW_CNT-1:0]  o_nwords,
  output logic               o_frame_err,
  output logic               o_ovf
);

  localparam logic [BW_CNT-1:0] CNT_MAX = {BW_CNT{1'b1}};
  localparam logic [BW_CNT-1:0] CNT_ONE = BW_CNT'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                carry_q;
  logic [BW_CNT-1:0]   cnt_q;

  logic                accept;
  logic                consume;
  logic                restart;
  logic                cin_used;
  logic [BW_DATA:0]    full_sum;
  logic [BW_CNT-1:0]   cnt_eff;
  logic [BW_CNT-1:0]   cnt_inc;
  logic                frame_err_d;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign consume = o_valid && i_ready;

  always_comb begin
    state_d     = state_q;
    restart     = 1'b0;
    cin_used    = 1'b0;
    full_sum    = '0;
    cnt_eff     = '0;
    cnt_inc     = '0;
    frame_err_d = 1'b0;

    // A beat in IDLE or any beat flagged first starts a fresh packet:
    // take i_cin and count from zero, dropping whatever was in progress.
    restart  = (state_q == IDLE) || i_first;
    cin_used = restart ? i_cin : carry_q;
    full_sum = {1'b0, i_a} + {1'b0, i_b} + {{BW_DATA{1'b0}}, cin_used};

    cnt_eff = restart ? '0 : cnt_q;
    cnt_inc = (cnt_eff == CNT_MAX) ? CNT_MAX : cnt_eff + CNT_ONE;

    // Saturation flags only the beat that first reaches CNT_MAX, so longer
    // packets produce a single pulse.
    frame_err_d = ((state_q == IDLE) && !i_first)
                || ((state_q == RUN) && i_first)
                || (!restart && (cnt_eff != CNT_MAX) && (cnt_inc == CNT_MAX));

    if (accept) begin
      state_d = i_last ? IDLE : RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      o_valid     <= 1'b0;
      o_sum       <= '0;
      o_last      <= 1'b0;
      o_cout      <= 1'b0;
      o_nwords    <= '0;
      o_frame_err <= 1'b0;
    end else if (accept) begin
      carry_q     <= i_last ? 1'b0 : full_sum[BW_DATA];
      cnt_q       <= i_last ? '0 : cnt_inc;
      o_valid     <= 1'b1;
      o_sum       <= full_sum[BW_DATA-1:0];
      o_last      <= i_last;
      o_cout      <= i_last ? full_sum[BW_DATA] : 1'b0;
      o_nwords    <= i_last ? cnt_inc : '0;
      o_frame_err <= frame_err_d;
    end else begin
      // The error flag is a pulse even while the result is held back.
      o_frame_err <= 1'b0;
      if (consume) begin
        o_valid  <= 1'b0;
        o_last   <= 1'b0;
        o_cout   <= 1'b0;
        o_nwords <= '0;
      end
    end
  end

`ifdef ADDER_SEQ_OVF_EN
  logic ovf_d;

  // Carry into the MSB is recovered from the MSB sum bit and both operand
  // MSBs; overflow is that carry differing from the carry out.
  assign ovf_d = full_sum[BW_DATA-1] ^ i_a[BW_DATA-1] ^ i_b[BW_DATA-1]
               ^ full_sum[BW_DATA];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ovf <= 1'b0;
    end else if (accept) begin
      o_ovf <= i_last ? ovf_d : 1'b0;
    end else if (consume) begin
      o_ovf <= 1'b0;
    end
  end
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_seq_chain.sv
// tb/tb_adder_seq_chain.sv - self-checking bench for adder_seq_chain

module tb_adder_seq_chain;

`ifdef ADDER_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic       i_first;
  logic       i_last;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       i_cin;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_sum;
  logic       o_last;
  logic       o_cout;
  logic [3:0] o_nwords;
  logic       o_frame_err;
  logic       o_ovf;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       first;
    logic       last;
    logic [7:0] sum;
    logic       cout;
    logic [3:0] nwords;
    logic       ovf;
    logic       ferr;
  } beat_t;

  beat_t bq[$];

  adder_seq_chain #(.BW_DATA(8), .BW_CNT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_first     (i_first),
    .i_last      (i_last),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_cin       (i_cin),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sum       (o_sum),
    .o_last      (o_last),
    .o_cout      (o_cout),
    .o_nwords    (o_nwords),
    .o_frame_err (o_frame_err),
    .o_ovf       (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               input logic first, input logic last, input logic [7:0] sum,
                               input logic cout, input logic [3:0] nwords, input logic ovf,
                               input logic ferr);
    beat_t t;
    t.a = a; t.b = b; t.cin = cin; t.first = first; t.last = last;
    t.sum = sum; t.cout = cout; t.nwords = nwords; t.ovf = ovf; t.ferr = ferr;
    bq.push_back(t);
  endfunction

  // Reference: whole packet added as one wide integer, then sliced per word.
  function automatic void gen_packet(input int n);
    logic [263:0] wa, wb, tot;
    logic         c0;
    beat_t        t;
    wa = '0; wb = '0;
    c0 = 1'($urandom_range(0, 1));
    for (int k = 0; k < n; k++) begin
      wa[8*k +: 8] = 8'($urandom);
      wb[8*k +: 8] = 8'($urandom);
    end
    tot = wa + wb + {263'd0, c0};
    for (int k = 0; k < n; k++) begin
      t.a      = wa[8*k +: 8];
      t.b      = wb[8*k +: 8];
      t.first  = (k == 0);
      t.last   = (k == n - 1);
      t.cin    = (k == 0) ? c0 : 1'($urandom_range(0, 1));
      t.sum    = tot[8*k +: 8];
      t.cout   = t.last ? tot[8*n] : 1'b0;
      t.nwords = t.last ? 4'((n > 15) ? 15 : n) : 4'd0;
      t.ovf    = (t.last && OVF_EN) ?
                 ((wa[8*n-1] == wb[8*n-1]) && (tot[8*n-1] != wa[8*n-1])) : 1'b0;
      t.ferr   = (k == 14);
      bq.push_back(t);
    end
  endfunction

  // Drives bq in lockstep with a model of the one-entry output register.
  task automatic run_queue(input int ready_pct, input int valid_pct);
    bit    exp_valid = 1'b0;
    bit    exp_ferr  = 1'b0;
    bit    acc, cons;
    beat_t held;
    int    budget = 0;
    while ((bq.size() > 0 || exp_valid) && budget < 20000) begin
      @(negedge clk);
      budget++;
      chk("valid", 32'(o_valid), 32'(exp_valid));
      chk("ferr", 32'(o_frame_err), 32'(exp_ferr));
      if (exp_valid) begin
        chk("sum", 32'(o_sum), 32'(held.sum));
        chk("last", 32'(o_last), 32'(held.last));
        chk("cout", 32'(o_cout), 32'(held.cout));
        chk("nwords", 32'(o_nwords), 32'(held.nwords));
        chk("ovf", 32'(o_ovf), 32'(held.ovf));
      end else begin
        chk("idle_flags", {29'd0, o_last, o_cout, o_ovf}, 32'd0);
        chk("idle_nwords", 32'(o_nwords), 32'd0);
      end
      i_ready = ($urandom_range(0, 99) < ready_pct);
      if (bq.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        i_valid = 1'b1;
        i_a = bq[0].a; i_b = bq[0].b; i_cin = bq[0].cin;
        i_first = bq[0].first; i_last = bq[0].last;
      end else begin
        i_valid = 1'b0;
        i_a = 8'($urandom); i_b = 8'($urandom); i_cin = 1'($urandom_range(0, 1));
        i_first = 1'($urandom_range(0, 1)); i_last = 1'($urandom_range(0, 1));
      end
      #1;
      chk("ready", 32'(o_ready), 32'(!exp_valid || i_ready));
      acc  = i_valid && (!exp_valid || i_ready);
      cons = exp_valid && i_ready;
      @(posedge clk);
      exp_ferr = 1'b0;
      if (acc) begin
        held = bq.pop_front();
        exp_valid = 1'b1;
        exp_ferr = held.ferr;
      end else if (cons) begin
        exp_valid = 1'b0;
      end
    end
    if (budget >= 20000) chk("queue_timeout", 32'(bq.size()), 32'd0);
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_first = 1'b0; i_last = 1'b0;
    i_a = 8'd0; i_b = 8'd0; i_cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_outs", {o_sum, o_nwords, o_last, o_cout, o_frame_err, o_ovf}, 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    rst = 1'b0;

    // Single beat, two-word packet, restart, overflow.
    push(8'hFF, 8'h01, 0, 1, 1, 8'h00, 1, 4'd1, 0, 0);
    push(8'hFF, 8'h01, 0, 1, 0, 8'h00, 0, 4'd0, 0, 0);
    push(8'h01, 8'h00, 0, 0, 1, 8'h02, 0, 4'd2, 0, 0);
    push(8'hFF, 8'h01, 0, 1, 0, 8'h00, 0, 4'd0, 0, 0);
    push(8'h10, 8'h20, 1, 1, 1, 8'h31, 0, 4'd1, 0, 1);
    push(8'h7F, 8'h01, 0, 1, 1, 8'h80, 0, 4'd1, OVF_EN, 0);
    run_queue(100, 100);

    // Backpressure: result held for 3 cycles while another beat waits.
    @(negedge clk);
    i_valid = 1'b1; i_ready = 1'b0; i_first = 1'b1; i_last = 1'b1;
    i_a = 8'h05; i_b = 8'h03; i_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_a = 8'h01; i_b = 8'h02;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(o_ready), 32'd0);
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_sum", 32'(o_sum), 32'h08);
      @(negedge clk);
    end
    i_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    i_valid = 1'b0;
    chk("bp_next_sum", 32'(o_sum), 32'h03);
    chk("bp_next_valid", 32'(o_valid), 32'd1);
    chk("bp_next_nwords", 32'(o_nwords), 32'd1);
    @(negedge clk);
    chk("bp_drained", 32'(o_valid), 32'd0);

    // Reset mid-packet, then a beat without i_first.
    i_valid = 1'b1; i_first = 1'b1; i_last = 1'b0; i_a = 8'hFF; i_b = 8'h01;
    @(negedge clk);
    i_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_outs", {o_sum, o_nwords, o_last, o_cout, o_frame_err, o_ovf}, 32'd0);
    push(8'h10, 8'h20, 1, 0, 1, 8'h31, 0, 4'd1, 0, 1);
    run_queue(100, 100);

    // Long packets reach counter saturation.
    gen_packet(15);
    gen_packet(18);
    run_queue(70, 80);

    // Random packets under random gaps and backpressure.
    for (int p = 0; p < 60; p++) gen_packet($urandom_range(1, 6));
    run_queue(60, 70);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
